// File: rtl/roi_pkg.sv
// Shared types and constants for the ROI calibration / tracking controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package roi_pkg;

  // Default coordinate width (12 bits covers a 4096-pixel axis).
  localparam int COORD_W_DEF = 12;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CAL_A  = 3'd1,
    CAL_B  = 3'd2,
    COMMIT = 3'd3,
    TRACK  = 3'd4
  } roi_state_t;

endpackage

// File: rtl/roi_reg.sv
// One ROI coordinate register with synchronous reset and write enable.
// Latency: write visible on q one cycle after we.
// Backpressure: none; we is honoured every cycle.
// Ports: CLK, RESET (sync, active-high), we, d -> q.
module roi_reg
  import roi_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               we,
  input  logic [COORD_W-1:0] d,
  output logic [COORD_W-1:0] q
);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/roi_cal_fsm.sv
// Calibrates NUM_ROI rectangles from mouse clicks, then supervises tracking and
// falls back to calibration after LOST_FRAMES consecutive untracked frames.
// Latency: state moves one cycle after click/frame event; ROI write visible at COMMIT+1.
// Backpressure: none; ABORT overrides every transition.
// Ports: CLK/RESET; CAL_START, ABORT, CLICK, CUR_X/Y, FRAME_START, TRACK_VALID in;
//        packed ROI corners + ROI_VALID, CAL_IDX, overlay/trace controls, ERR_DEGEN, LOST out.
module roi_cal_fsm
  import roi_pkg::*;
#(
  parameter int COORD_W     = COORD_W_DEF,
  parameter int NUM_ROI     = 2,
  parameter int LOST_FRAMES = 30
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       CAL_START,
  input  logic                       ABORT,
  input  logic                       CLICK,
  input  logic [COORD_W-1:0]         CUR_X,
  input  logic [COORD_W-1:0]         CUR_Y,
  input  logic                       FRAME_START,
  input  logic                       TRACK_VALID,
  output logic [NUM_ROI*COORD_W-1:0] ROI_TLX,
  output logic [NUM_ROI*COORD_W-1:0] ROI_TLY,
  output logic [NUM_ROI*COORD_W-1:0] ROI_BRX,
  output logic [NUM_ROI*COORD_W-1:0] ROI_BRY,
  output logic [NUM_ROI-1:0]         ROI_VALID,
  output logic [$clog2(NUM_ROI):0]   CAL_IDX,
  output logic                       SHOW_BALL,
  output logic                       SHOW_BOX,
  output logic                       SHOW_GAIN,
  output logic                       RESET_TRACED,
  output logic                       WRITE_TRACED,
  output logic                       ERR_DEGEN,
  output logic                       LOST
);

  localparam int IW = $clog2(NUM_ROI) + 1;
  localparam int LW = $clog2(LOST_FRAMES + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_ROI - 1);
  localparam logic [LW-1:0] LOST_LAST = LW'(LOST_FRAMES - 1);
  localparam logic [LW-1:0] LOST_MAX  = LW'(LOST_FRAMES);

  roi_state_t state, state_nxt;

  logic               click_q;
  logic               click_ev;
  logic [COORD_W-1:0] ax, ay, bx, by;
  logic [COORD_W-1:0] tlx, tly, brx, bry;
  logic               degen;
  logic [LW-1:0]      lost_cnt;
  logic               lost_hit;
  logic [IW-1:0]      cal_idx;
  logic [NUM_ROI-1:0] roi_valid;
  logic [NUM_ROI-1:0] roi_we_vec;

  // Decisions from the comb process
  logic roi_we, lat_a, lat_b, idx_clr, idx_inc, valid_clr;

  // A held button gives one event; after reset click_q is 0, but any event in
  // IDLE is ignored, so a button held through reset never latches a corner.
  assign click_ev = CLICK & ~click_q;

  // Corner normalisation, unsigned compare.
  assign tlx   = (ax < bx) ? ax : bx;
  assign brx   = (ax < bx) ? bx : ax;
  assign tly   = (ay < by) ? ay : by;
  assign bry   = (ay < by) ? by : ay;
  assign degen = (ax == bx) | (ay == by);

  // This frame's miss would bring the counter to LOST_FRAMES.
  assign lost_hit = FRAME_START & ~TRACK_VALID & (lost_cnt == LOST_LAST);

  always_comb begin
    state_nxt = state;
    roi_we    = 1'b0;
    lat_a     = 1'b0;
    lat_b     = 1'b0;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    valid_clr = 1'b0;
    ERR_DEGEN = 1'b0;
    LOST      = 1'b0;
    if (ABORT) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (CAL_START) begin
            state_nxt = CAL_A;
            idx_clr   = 1'b1;
            valid_clr = 1'b1;
          end
        end
        CAL_A: begin
          if (click_ev) begin
            lat_a     = 1'b1;
            state_nxt = CAL_B;
          end
        end
        CAL_B: begin
          if (click_ev) begin
            lat_b     = 1'b1;
            state_nxt = COMMIT;
          end
        end
        COMMIT: begin
          if (degen) begin
            ERR_DEGEN = 1'b1;
            state_nxt = CAL_A;
          end else begin
            roi_we = 1'b1;
            if (cal_idx == LAST_IDX) begin
              state_nxt = TRACK;
            end else begin
              idx_inc   = 1'b1;
              state_nxt = CAL_A;
            end
          end
        end
        TRACK: begin
          if (lost_hit) begin
            LOST      = 1'b1;
            valid_clr = 1'b1;
            idx_clr   = 1'b1;
            state_nxt = CAL_A;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      click_q   <= 1'b0;
      ax        <= '0;
      ay        <= '0;
      bx        <= '0;
      by        <= '0;
      lost_cnt  <= '0;
      cal_idx   <= '0;
      roi_valid <= '0;
    end else begin
      state   <= state_nxt;
      click_q <= CLICK;
      if (lat_a) begin
        ax <= CUR_X;
        ay <= CUR_Y;
      end
      if (lat_b) begin
        bx <= CUR_X;
        by <= CUR_Y;
      end
      if (idx_clr) begin
        cal_idx <= '0;
      end else if (idx_inc) begin
        cal_idx <= cal_idx + 1'b1;
      end
      if (valid_clr) begin
        roi_valid <= '0;
      end else begin
        roi_valid <= roi_valid | roi_we_vec;
      end
      // Held at zero outside TRACK, which gives the clear-on-entry.
      if (state != TRACK) begin
        lost_cnt <= '0;
      end else if (FRAME_START) begin
        if (TRACK_VALID) begin
          lost_cnt <= '0;
        end else if (lost_cnt != LOST_MAX) begin
          lost_cnt <= lost_cnt + 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_ROI; gi++) begin : g_roi
    localparam logic [IW-1:0] MY_IDX = IW'(gi);
    assign roi_we_vec[gi] = roi_we & (cal_idx == MY_IDX);

    roi_reg #(.COORD_W(COORD_W)) u_tlx (
      .CLK(CLK), .RESET(RESET), .we(roi_we_vec[gi]), .d(tlx),
      .q(ROI_TLX[gi*COORD_W +: COORD_W]));
    roi_reg #(.COORD_W(COORD_W)) u_tly (
      .CLK(CLK), .RESET(RESET), .we(roi_we_vec[gi]), .d(tly),
      .q(ROI_TLY[gi*COORD_W +: COORD_W]));
    roi_reg #(.COORD_W(COORD_W)) u_brx (
      .CLK(CLK), .RESET(RESET), .we(roi_we_vec[gi]), .d(brx),
      .q(ROI_BRX[gi*COORD_W +: COORD_W]));
    roi_reg #(.COORD_W(COORD_W)) u_bry (
      .CLK(CLK), .RESET(RESET), .we(roi_we_vec[gi]), .d(bry),
      .q(ROI_BRY[gi*COORD_W +: COORD_W]));
  end

  assign ROI_VALID = roi_valid;
  assign CAL_IDX   = cal_idx;

  // Overlay and trace controls are pure decodes of the registered state.
  always_comb begin
    SHOW_BALL    = 1'b0;
    SHOW_BOX     = 1'b0;
    SHOW_GAIN    = 1'b0;
    RESET_TRACED = 1'b0;
    WRITE_TRACED = 1'b0;
    case (state)
      IDLE: begin
        SHOW_GAIN    = 1'b1;
        RESET_TRACED = 1'b1;
      end
      CAL_A, CAL_B, COMMIT: begin
        SHOW_GAIN    = 1'b1;
        RESET_TRACED = 1'b1;
        SHOW_BALL    = 1'b1;
      end
      TRACK: begin
        SHOW_BOX     = 1'b1;
        WRITE_TRACED = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_roi_cal_fsm.sv
// Directed bench: u0 is a 1-ROI / LOST_FRAMES=1 instance, u1 a 3-ROI / LOST_FRAMES=4
// instance; both share stimulus and are reset between scenarios.
module tb_roi_cal_fsm;
  import roi_pkg::*;

  logic CLK = 1'b0;
  logic RESET, CAL_START, ABORT, CLICK, FRAME_START, TRACK_VALID;
  logic [11:0] CUR_X, CUR_Y;

  logic [11:0] a_tlx, a_tly, a_brx, a_bry;
  logic [0:0]  a_valid, a_idx;
  logic        a_ball, a_box, a_gain, a_rst_tr, a_wr_tr, a_degen, a_lost;

  logic [35:0] b_tlx, b_tly, b_brx, b_bry;
  logic [2:0]  b_valid, b_idx;
  logic        b_ball, b_box, b_gain, b_rst_tr, b_wr_tr, b_degen, b_lost;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  roi_cal_fsm #(.COORD_W(12), .NUM_ROI(1), .LOST_FRAMES(1)) u0 (
    .CLK(CLK), .RESET(RESET), .CAL_START(CAL_START), .ABORT(ABORT), .CLICK(CLICK),
    .CUR_X(CUR_X), .CUR_Y(CUR_Y), .FRAME_START(FRAME_START), .TRACK_VALID(TRACK_VALID),
    .ROI_TLX(a_tlx), .ROI_TLY(a_tly), .ROI_BRX(a_brx), .ROI_BRY(a_bry),
    .ROI_VALID(a_valid), .CAL_IDX(a_idx), .SHOW_BALL(a_ball), .SHOW_BOX(a_box),
    .SHOW_GAIN(a_gain), .RESET_TRACED(a_rst_tr), .WRITE_TRACED(a_wr_tr),
    .ERR_DEGEN(a_degen), .LOST(a_lost));

  roi_cal_fsm #(.COORD_W(12), .NUM_ROI(3), .LOST_FRAMES(4)) u1 (
    .CLK(CLK), .RESET(RESET), .CAL_START(CAL_START), .ABORT(ABORT), .CLICK(CLICK),
    .CUR_X(CUR_X), .CUR_Y(CUR_Y), .FRAME_START(FRAME_START), .TRACK_VALID(TRACK_VALID),
    .ROI_TLX(b_tlx), .ROI_TLY(b_tly), .ROI_BRX(b_brx), .ROI_BRY(b_bry),
    .ROI_VALID(b_valid), .CAL_IDX(b_idx), .SHOW_BALL(b_ball), .SHOW_BOX(b_box),
    .SHOW_GAIN(b_gain), .RESET_TRACED(b_rst_tr), .WRITE_TRACED(b_wr_tr),
    .ERR_DEGEN(b_degen), .LOST(b_lost));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Click edge sampled at the next rising edge; leaves the button released.
  task automatic press(input int x, input int y);
    CUR_X = 12'(x);
    CUR_Y = 12'(y);
    CLICK = 1'b1;
    tick();
    CLICK = 1'b0;
  endtask

  task automatic click(input int x, input int y);
    press(x, y);
    tick();
  endtask

  task automatic frame(input logic v, input logic exp_lost, input string tag);
    FRAME_START = 1'b1;
    TRACK_VALID = v;
    #1;
    chk(tag, 64'(b_lost), 64'(exp_lost));
    tick();
    FRAME_START = 1'b0;
    TRACK_VALID = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; CAL_START = 1'b0; ABORT = 1'b0; CLICK = 1'b0;
    FRAME_START = 1'b0; TRACK_VALID = 1'b0; CUR_X = '0; CUR_Y = '0;
    do_reset();

    // Reset decode
    chk("rst_state", 64'(u0.state), 64'(IDLE));
    chk("rst_gain",  64'(a_gain), 64'd1);
    chk("rst_rtr",   64'(a_rst_tr), 64'd1);
    chk("rst_ball",  64'(a_ball), 64'd0);
    chk("rst_box",   64'(a_box), 64'd0);
    chk("rst_wtr",   64'(a_wr_tr), 64'd0);
    chk("rst_valid", 64'(b_valid), 64'd0);
    chk("rst_idx",   64'(b_idx), 64'd0);
    chk("rst_tlx",   64'(b_tlx), 64'd0);
    chk("rst_bry",   64'(b_bry), 64'd0);

    // Single rectangle on the 1-ROI instance
    CAL_START = 1'b1; tick(); CAL_START = 1'b0;
    chk("s1_cal_a", 64'(u0.state), 64'(CAL_A));
    chk("s1_ball",  64'(a_ball), 64'd1);
    click(100, 50);
    chk("s1_cal_b", 64'(u0.state), 64'(CAL_B));
    press(20, 200);
    chk("s1_commit",  64'(u0.state), 64'(COMMIT));
    chk("s1_nvalid",  64'(a_valid), 64'd0);
    tick();
    chk("s1_track", 64'(u0.state), 64'(TRACK));
    chk("s1_tlx",   64'(a_tlx), 64'd20);
    chk("s1_tly",   64'(a_tly), 64'd50);
    chk("s1_brx",   64'(a_brx), 64'd100);
    chk("s1_bry",   64'(a_bry), 64'd200);
    chk("s1_valid", 64'(a_valid), 64'd1);
    chk("s1_box",   64'(a_box), 64'd1);
    chk("s1_wtr",   64'(a_wr_tr), 64'd1);
    chk("s1_gain",  64'(a_gain), 64'd0);
    chk("s1_rtr",   64'(a_rst_tr), 64'd0);
    chk("s1_b_state", 64'(u1.state), 64'(CAL_A));
    chk("s1_b_idx",   64'(b_idx), 64'd1);
    chk("s1_b_valid", 64'(b_valid), 64'd1);
    chk("s1_b_tlx",   64'(b_tlx), 64'd20);

    // LOST_FRAMES=1: first missed frame exits
    FRAME_START = 1'b1; TRACK_VALID = 1'b0; #1;
    chk("s1_lost",   64'(a_lost), 64'd1);
    chk("s1_b_nolost", 64'(b_lost), 64'd0);
    tick();
    FRAME_START = 1'b0;
    chk("s1_lost_clr",  64'(a_lost), 64'd0);
    chk("s1_lost_st",   64'(u0.state), 64'(CAL_A));
    chk("s1_lost_vld",  64'(a_valid), 64'd0);
    chk("s1_lost_idx",  64'(a_idx), 64'd0);
    chk("s1_keep_tlx",  64'(a_tlx), 64'd20);

    // Button held through reset, then held in CAL_A: no event
    CLICK = 1'b1;
    do_reset();
    CAL_START = 1'b1; tick(); CAL_START = 1'b0;
    tick();
    chk("s2_held_rst", 64'(u1.state), 64'(CAL_A));
    CUR_X = 12'd7; CUR_Y = 12'd8; CLICK = 1'b0; tick();
    CLICK = 1'b1; tick();
    CUR_X = 12'd9; CUR_Y = 12'd9;
    for (int i = 0; i < 9; i++) tick();
    chk("s2_hold_b", 64'(u1.state), 64'(CAL_B));
    CLICK = 1'b0; tick();
    click(50, 60);
    chk("s2_state", 64'(u1.state), 64'(CAL_A));
    chk("s2_tlx", 64'(b_tlx), 64'd7);
    chk("s2_tly", 64'(b_tly), 64'd8);
    chk("s2_brx", 64'(b_brx), 64'd50);
    chk("s2_bry", 64'(b_bry), 64'd60);
    chk("s2_idx", 64'(b_idx), 64'd1);

    // Degenerate rectangle (same X)
    click(30, 40);
    press(30, 90);
    chk("s3_commit", 64'(u1.state), 64'(COMMIT));
    chk("s3_degen",  64'(b_degen), 64'd1);
    tick();
    chk("s3_degen_clr", 64'(b_degen), 64'd0);
    chk("s3_state", 64'(u1.state), 64'(CAL_A));
    chk("s3_idx",   64'(b_idx), 64'd1);
    chk("s3_valid", 64'(b_valid), 64'd1);
    chk("s3_tlx",   64'(b_tlx), 64'd7);

    // ABORT together with corner-B click
    click(11, 22);
    chk("s6_cal_b", 64'(u1.state), 64'(CAL_B));
    CUR_X = 12'd33; CUR_Y = 12'd44; CLICK = 1'b1; ABORT = 1'b1;
    tick();
    chk("s6_idle",  64'(u1.state), 64'(IDLE));
    chk("s6_valid", 64'(b_valid), 64'd1);
    chk("s6_tlx",   64'(b_tlx), 64'd7);
    chk("s6_bry",   64'(b_bry), 64'd60);
    chk("s6_ball",  64'(b_ball), 64'd0);
    chk("s6_gain",  64'(b_gain), 64'd1);
    chk("s6_rtr",   64'(b_rst_tr), 64'd1);
    chk("s6_box",   64'(b_box), 64'd0);
    // CAL_START already high as IDLE is reached: restarts immediately
    ABORT = 1'b0; CLICK = 1'b0; CAL_START = 1'b1;
    tick();
    CAL_START = 1'b0;
    chk("s6_restart", 64'(u1.state), 64'(CAL_A));
    chk("s6_rs_vld",  64'(b_valid), 64'd0);
    chk("s6_rs_idx",  64'(b_idx), 64'd0);

    // Three rectangles
    click(100, 50); click(20, 200);
    chk("s4_idx1", 64'(b_idx), 64'd1);
    click(300, 10); click(200, 400);
    chk("s4_idx2", 64'(b_idx), 64'd2);
    click(5, 6); press(1, 2); tick();
    chk("s4_track", 64'(u1.state), 64'(TRACK));
    chk("s4_idx",   64'(b_idx), 64'd2);
    chk("s4_valid", 64'(b_valid), 64'h7);
    chk("s4_tlx", 64'(b_tlx), {28'd0, 12'd1, 12'd200, 12'd20});
    chk("s4_tly", 64'(b_tly), {28'd0, 12'd2, 12'd10,  12'd50});
    chk("s4_brx", 64'(b_brx), {28'd0, 12'd5, 12'd300, 12'd100});
    chk("s4_bry", 64'(b_bry), {28'd0, 12'd6, 12'd400, 12'd200});

    // Lost-track: miss, miss, hit, then four misses
    frame(1'b0, 1'b0, "s5_f1");
    frame(1'b0, 1'b0, "s5_f2");
    frame(1'b1, 1'b0, "s5_f3");
    frame(1'b0, 1'b0, "s5_f4");
    frame(1'b0, 1'b0, "s5_f5");
    frame(1'b0, 1'b0, "s5_f6");
    chk("s5_still_track", 64'(u1.state), 64'(TRACK));
    frame(1'b0, 1'b1, "s5_f7");
    chk("s5_cal_a", 64'(u1.state), 64'(CAL_A));
    chk("s5_valid", 64'(b_valid), 64'd0);
    chk("s5_idx",   64'(b_idx), 64'd0);
    chk("s5_lost_clr", 64'(b_lost), 64'd0);
    chk("s5_keep_brx", 64'(b_brx), {28'd0, 12'd5, 12'd300, 12'd100});

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/roi_cal_fsm.md
# roi_cal_fsm

Parametrised calibration and tracking controller for the camera/ball pipeline. Collects `NUM_ROI` rectangular regions of interest from mouse clicks and normalises each rectangle's corners. Supervises tracking and returns to calibration when the tracked object is lost for `LOST_FRAMES` consecutive frames. Sits between the USB/NIOS mouse path, the tracker and the VGA overlay, and owns the ROI coordinate registers.

## Interface
Parameters:
- `COORD_W`, 12: coordinate width in bits.
- `NUM_ROI`, 2: number of regions calibrated per pass, ≥1.
- `LOST_FRAMES`, 30: consecutive frames without a valid track before re-calibration, ≥1.

Ports:
- `CLK` in 1: system clock.
- `RESET` in 1: reset RESET, synchronous, active-high; clock CLK.
- `CAL_START` in 1: level; starts calibration from IDLE.
- `ABORT` in 1: level; forces IDLE from any state.
- `CLICK` in 1: mouse button level, already synchronous to CLK.
- `CUR_X`, `CUR_Y` in COORD_W: cursor position.
- `FRAME_START` in 1: one-cycle pulse per video frame.
- `TRACK_VALID` in 1: tracker result for the current frame; sampled on `FRAME_START`.
- `ROI_TLX`, `ROI_TLY`, `ROI_BRX`, `ROI_BRY` out NUM_ROI*COORD_W: packed ROI corners; ROI *i* occupies bits [i*COORD_W +: COORD_W].
- `ROI_VALID` out NUM_ROI: ROI *i* holds an accepted rectangle.
- `CAL_IDX` out $clog2(NUM_ROI)+1: index of the ROI being calibrated.
- `SHOW_BALL`, `SHOW_BOX`, `SHOW_GAIN` out 1: overlay controls.
- `RESET_TRACED`, `WRITE_TRACED` out 1: trace-memory controls.
- `ERR_DEGEN` out 1: one-cycle pulse when a rectangle is rejected.
- `LOST` out 1: one-cycle pulse on a lost-track exit.

## Operation
- Click event: `click_ev = CLICK & ~click_q`, where `click_q` is `CLICK` registered. Holding the button produces exactly one event; no release states are needed.
- States:
  - IDLE → CAL_A on `CAL_START`. Entry clears all `ROI_VALID` bits and sets `CAL_IDX` to 0.
  - CAL_A: on `click_ev`, latch (`CUR_X`, `CUR_Y`) as corner A, go to CAL_B.
  - CAL_B: on `click_ev`, latch corner B, go to COMMIT.
  - COMMIT, one cycle:
    - TLX=min(Ax,Bx), BRX=max(Ax,Bx); same rule for Y. Comparisons are unsigned, COORD_W wide.
    - If Ax==Bx or Ay==By: pulse `ERR_DEGEN`, leave the ROI unchanged, go to CAL_A with the same `CAL_IDX`.
    - Otherwise write ROI[`CAL_IDX`], set `ROI_VALID[CAL_IDX]`, and go to TRACK if `CAL_IDX`==NUM_ROI-1. If not, increment `CAL_IDX` and go to CAL_A.
  - TRACK: the lost counter clears on entry.
    - On `FRAME_START` with `TRACK_VALID`=1: counter ← 0.
    - On `FRAME_START` with `TRACK_VALID`=0: counter increments.
    - When the counter reaches LOST_FRAMES: pulse `LOST`, clear `ROI_VALID`, set `CAL_IDX` to 0, go to CAL_A.
- `ABORT` has priority over every transition. It forces IDLE next cycle and leaves ROI registers and `ROI_VALID` unchanged.
- Outputs are decoded from the registered state:
  - `SHOW_GAIN`=1 and `RESET_TRACED`=1 in IDLE, CAL_A, CAL_B, COMMIT.
  - `SHOW_BALL`=1 in CAL_A, CAL_B, COMMIT.
  - `SHOW_BOX`=1, `WRITE_TRACED`=1, `RESET_TRACED`=0, `SHOW_GAIN`=0 in TRACK.

## Timing
- Reset values:
  - State IDLE.
  - All ROI coordinates 0, `ROI_VALID` 0, `CAL_IDX` 0, `click_q` 0, lost counter 0.
  - `SHOW_GAIN`=1, `RESET_TRACED`=1, all other outputs 0.
- Latencies:
  - A click edge at cycle n moves the state at n+1.
  - The COMMIT write is visible on the ROI outputs at COMMIT+1.
  - The lost exit moves the state one cycle after the `FRAME_START` that reaches LOST_FRAMES.
- Boundary and simultaneous events:
  - `CLICK` asserted during RESET, with the button still held afterwards, produces no event.
  - Corner-B click arriving in the same cycle as `ABORT`: `ABORT` wins and no corner is latched.
  - `CAL_START` held high after reaching IDLE: recalibration starts immediately.
  - LOST_FRAMES=1: the first invalid frame triggers the exit.
  - The lost counter saturates and must be $clog2(LOST_FRAMES+1) bits wide.
  - RESET mid-calibration discards latched corners.

## Structure
- `roi_pkg` holds the state enum `roi_state_t` (IDLE, CAL_A, CAL_B, COMMIT, TRACK) and the default COORD_W constant.
- Sub-module `roi_reg`: parametrised COORD_W register with synchronous reset and write enable. It is instantiated 4×NUM_ROI times through a generate loop.
- The FSM, the edge detector and the lost counter stay in `roi_cal_fsm`.

## Test plan
- Reset, then `CAL_START`; click (100,50) then (20,200) with NUM_ROI=1:
  - ROI0 = TL(20,50), BR(100,200).
  - `ROI_VALID`=1 and state TRACK at commit+1.
- Button held for 10 cycles in CAL_A: only one corner is latched, the state stays in CAL_B, and no double capture occurs.
- Clicks (30,40) then (30,90): `ERR_DEGEN` pulses once, state returns to CAL_A, `CAL_IDX` is unchanged, `ROI_VALID`=0.
- NUM_ROI=3: three valid rectangles give `CAL_IDX` sequence 0,1,2, TRACK is entered, and all ROIs hold the correct normalised values.
- In TRACK with LOST_FRAMES=4: invalid, invalid, valid, then 4 invalid frames produce `LOST` on the 7th `FRAME_START`, followed by CAL_A with `ROI_VALID`=0.
- `ABORT` asserted in CAL_B on the same cycle as the second click: state goes to IDLE, the ROI is unchanged, and outputs return to reset decode.
